// File: rtl/lc4_arith_rs.sv
// Reservation station for the LC4 out-of-order arithmetic pipe: holds dispatched insns,
// wakes sources from the CDB, and issues the oldest ready entry each cycle.
module lc4_arith_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [15:0]      disp_insn,
  input  logic [15:0]      disp_pc,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic             disp_r1_rdy,
  input  logic [15:0]      disp_r1_val,
  input  logic [TAG_W-1:0] disp_r1_tag,
  input  logic             disp_r2_rdy,
  input  logic [15:0]      disp_r2_val,
  input  logic [TAG_W-1:0] disp_r2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [15:0]      iss_insn,
  output logic [15:0]      iss_pc,
  output logic [15:0]      iss_r1data,
  output logic [15:0]      iss_r2data,
  output logic [TAG_W-1:0] iss_tag,
  output logic [3:0]       count
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef struct packed {
    logic [15:0]      insn;
    logic [15:0]      pc;
    logic [TAG_W-1:0] tag;
    logic [15:0]      r1_val;
    logic [TAG_W-1:0] r1_tag;
    logic [15:0]      r2_val;
    logic [TAG_W-1:0] r2_tag;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] r1_rdy_q;
  logic [DEPTH-1:0] r2_rdy_q;
  // older_q[i][j] is set when entry i was dispatched before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [3:0]       count_q;

  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] is_oldest;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_found;
  logic [IDX_W-1:0] iss_idx;
  logic             disp_fire;
  logic             iss_fire;
  logic             r1_bypass;
  logic             r2_bypass;
  logic [3:0]       count_n;

  assign disp_ready = (count_q < DEPTH_C);
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign eligible   = valid_q & r1_rdy_q & r2_rdy_q;
  assign iss_valid  = (|eligible) && !flush;
  assign iss_fire   = iss_valid && iss_ready;
  assign r1_bypass  = !disp_r1_rdy && cdb_valid && (disp_r1_tag == cdb_tag);
  assign r2_bypass  = !disp_r2_rdy && cdb_valid && (disp_r2_tag == cdb_tag);
  assign count_n    = count_q + {3'b000, disp_fire} - {3'b000, iss_fire};
  assign count      = count_q;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // An eligible entry is the oldest if no other eligible entry was dispatched before it.
  always_comb begin
    is_oldest = eligible;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && older_q[j][i]) is_oldest[i] = 1'b0;
      end
    end
  end

  always_comb begin
    iss_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (is_oldest[i]) iss_idx = IDX_W'(i);
    end
  end

  always_comb begin
    iss_insn   = '0;
    iss_pc     = '0;
    iss_r1data = '0;
    iss_r2data = '0;
    iss_tag    = '0;
    if (iss_valid) begin
      iss_insn   = ent_q[iss_idx].insn;
      iss_pc     = ent_q[iss_idx].pc;
      iss_r1data = ent_q[iss_idx].r1_val;
      iss_r2data = ent_q[iss_idx].r2_val;
      iss_tag    = ent_q[iss_idx].tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      r1_rdy_q <= '0;
      r2_rdy_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && valid_q[i] && !r1_rdy_q[i] && ent_q[i].r1_tag == cdb_tag)
          r1_rdy_q[i] <= 1'b1;
        if (cdb_valid && valid_q[i] && !r2_rdy_q[i] && ent_q[i].r2_tag == cdb_tag)
          r2_rdy_q[i] <= 1'b1;
      end
      if (iss_fire) valid_q[iss_idx] <= 1'b0;
      if (disp_fire) begin
        valid_q[alloc_idx]  <= 1'b1;
        r1_rdy_q[alloc_idx] <= disp_r1_rdy || r1_bypass;
        r2_rdy_q[alloc_idx] <= disp_r2_rdy || r2_bypass;
        older_q[alloc_idx]  <= '0;
        for (int j = 0; j < DEPTH; j++) older_q[j][alloc_idx] <= valid_q[j];
      end
      count_q <= count_n;
    end
  end

  // NOTE: payload storage has no reset; it is only observed through valid/ready bits,
  // and the issue outputs are gated to zero whenever nothing is issuing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && !r1_rdy_q[i] && ent_q[i].r1_tag == cdb_tag) ent_q[i].r1_val <= cdb_data;
      if (cdb_valid && !r2_rdy_q[i] && ent_q[i].r2_tag == cdb_tag) ent_q[i].r2_val <= cdb_data;
    end
    if (disp_fire) begin
      ent_q[alloc_idx].insn   <= disp_insn;
      ent_q[alloc_idx].pc     <= disp_pc;
      ent_q[alloc_idx].tag    <= disp_tag;
      ent_q[alloc_idx].r1_val <= r1_bypass ? cdb_data : disp_r1_val;
      ent_q[alloc_idx].r1_tag <= disp_r1_tag;
      ent_q[alloc_idx].r2_val <= r2_bypass ? cdb_data : disp_r2_val;
      ent_q[alloc_idx].r2_tag <= disp_r2_tag;
    end
  end

endmodule

// File: tb/tb_lc4_arith_rs.sv
// Directed bench for lc4_arith_rs: issue latency, wakeup, bypass, age order, stall, flush, reset.
module tb_lc4_arith_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [15:0] disp_insn, disp_pc;
  logic [3:0]  disp_tag;
  logic        disp_r1_rdy, disp_r2_rdy;
  logic [15:0] disp_r1_val, disp_r2_val;
  logic [3:0]  disp_r1_tag, disp_r2_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [15:0] iss_insn, iss_pc, iss_r1data, iss_r2data;
  logic [3:0]  iss_tag;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  lc4_arith_rs #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_insn(disp_insn), .disp_pc(disp_pc), .disp_tag(disp_tag),
    .disp_r1_rdy(disp_r1_rdy), .disp_r1_val(disp_r1_val), .disp_r1_tag(disp_r1_tag),
    .disp_r2_rdy(disp_r2_rdy), .disp_r2_val(disp_r2_val), .disp_r2_tag(disp_r2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_insn(iss_insn), .iss_pc(iss_pc), .iss_r1data(iss_r1data), .iss_r2data(iss_r2data),
    .iss_tag(iss_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked in the same window.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [15:0] insn, input logic [15:0] pc, input logic [3:0] tag,
                      input logic r1r, input logic [15:0] r1v, input logic [3:0] r1t,
                      input logic r2r, input logic [15:0] r2v, input logic [3:0] r2t);
    disp_valid  = 1'b1;
    disp_insn   = insn;
    disp_pc     = pc;
    disp_tag    = tag;
    disp_r1_rdy = r1r;
    disp_r1_val = r1v;
    disp_r1_tag = r1t;
    disp_r2_rdy = r2r;
    disp_r2_val = r2v;
    disp_r2_tag = r2t;
  endtask

  task automatic cdb(input logic v, input logic [3:0] t, input logic [15:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0;
    disp(16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
    disp_valid = 1'b0;
    cdb(1'b0, 4'h0, 16'h0);
    #2;
    check("rst_count", count, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_insn", iss_insn, 0);
    #10 rst = 1'b0;
    tick();

    // T1: both sources ready, issues the next cycle.
    iss_ready = 1'b1;
    disp(16'h1234, 16'h0100, 4'd1, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
    tick();
    disp_valid = 1'b0;
    check("t1_iss_valid", iss_valid, 1);
    check("t1_r1data", iss_r1data, 5);
    check("t1_r2data", iss_r2data, 7);
    check("t1_tag", iss_tag, 1);
    check("t1_insn", iss_insn, 16'h1234);
    check("t1_pc", iss_pc, 16'h0100);
    check("t1_count_1", count, 1);
    tick();
    check("t1_count_0", count, 0);
    check("t1_idle", iss_valid, 0);
    check("t1_r1data_zero", iss_r1data, 0);

    // T2: src1 waits on tag 9, broadcast two cycles later.
    disp(16'h2000, 16'h0102, 4'd3, 1'b0, 16'h0, 4'd9, 1'b1, 16'h0022, 4'd0);
    tick();
    disp_valid = 1'b0;
    check("t2_wait_a", iss_valid, 0);
    check("t2_count", count, 1);
    tick();
    check("t2_wait_b", iss_valid, 0);
    cdb(1'b1, 4'd9, 16'h00AA);
    #1 check("t2_no_cdb_bypass", iss_valid, 0);
    tick();
    cdb(1'b0, 4'd0, 16'h0);
    check("t2_iss_valid", iss_valid, 1);
    check("t2_r1data", iss_r1data, 16'h00AA);
    check("t2_r2data", iss_r2data, 16'h0022);
    check("t2_tag", iss_tag, 3);
    tick();
    check("t2_count_0", count, 0);

    // T3: fill with waiting entries (rob tags 4..7, src1 tags 8..11).
    for (int i = 0; i < 4; i++) begin
      disp(16'h3000 + 16'(i), 16'h0200 + 16'(i), 4'(i + 4), 1'b0, 16'h0, 4'(i + 8),
           1'b1, 16'h0050, 4'd0);
      tick();
    end
    disp_valid = 1'b0;
    check("t3_full_count", count, 4);
    check("t3_full_ready", disp_ready, 0);
    check("t3_none_eligible", iss_valid, 0);
    disp(16'h3FFF, 16'h02FF, 4'd12, 1'b1, 16'h1, 4'd0, 1'b1, 16'h2, 4'd0);
    tick();
    disp_valid = 1'b0;
    check("t3_fifth_ignored_count", count, 4);
    check("t3_fifth_ignored_iss", iss_valid, 0);
    cdb(1'b1, 4'd10, 16'h0333);
    tick();
    cdb(1'b0, 4'd0, 16'h0);
    check("t3_wake_valid", iss_valid, 1);
    check("t3_wake_tag", iss_tag, 6);
    check("t3_wake_r1data", iss_r1data, 16'h0333);
    check("t3_same_cycle_ready", disp_ready, 0);
    tick();
    check("t3_count_3", count, 3);
    check("t3_ready_again", disp_ready, 1);
    check("t3_only_one", iss_valid, 0);

    // T6a: flush with 3 valid entries and a dispatch pending.
    flush = 1'b1;
    disp(16'h6000, 16'h0600, 4'd13, 1'b1, 16'h1, 4'd0, 1'b1, 16'h2, 4'd0);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_iss", iss_valid, 0);
    cdb(1'b1, 4'd8, 16'h0888);
    tick();
    cdb(1'b0, 4'd0, 16'h0);
    check("t6_dropped_dispatch", count, 0);
    check("t6_no_stale_wake", iss_valid, 0);

    // T4: A older than B, stalled for 3 cycles.
    iss_ready = 1'b0;
    disp(16'hA000, 16'h0A00, 4'd1, 1'b1, 16'd3, 4'd0, 1'b1, 16'd4, 4'd0);
    tick();
    disp(16'hB000, 16'h0B00, 4'd2, 1'b1, 16'd5, 4'd0, 1'b1, 16'd6, 4'd0);
    tick();
    disp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t4_hold_tag", iss_tag, 1);
      check("t4_hold_r1data", iss_r1data, 3);
      if (c < 2) tick();
    end
    flush = 1'b1;
    #1 check("t4_flush_masks_issue", iss_valid, 0);
    flush = 1'b0;
    #1 check("t4_unmasked", iss_valid, 1);
    iss_ready = 1'b1;
    tick();
    check("t4_b_tag", iss_tag, 2);
    check("t4_b_r1data", iss_r1data, 5);
    check("t4_b_r2data", iss_r2data, 6);
    check("t4_count_1", count, 1);
    tick();
    check("t4_count_0", count, 0);

    // Age order: younger R lands in a lower index than older Q.
    iss_ready = 1'b0;
    disp(16'h7001, 16'h0701, 4'd1, 1'b1, 16'h11, 4'd0, 1'b1, 16'h12, 4'd0);
    tick();
    disp(16'h7002, 16'h0702, 4'd2, 1'b0, 16'h0, 4'd13, 1'b1, 16'h22, 4'd0);
    tick();
    disp_valid = 1'b0;
    check("age_p_tag", iss_tag, 1);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("age_count_1", count, 1);
    check("age_q_waiting", iss_valid, 0);
    disp(16'h7003, 16'h0703, 4'd3, 1'b1, 16'h31, 4'd0, 1'b1, 16'h32, 4'd0);
    tick();
    disp_valid = 1'b0;
    check("age_r_tag", iss_tag, 3);
    cdb(1'b1, 4'd13, 16'h0D0D);
    tick();
    cdb(1'b0, 4'd0, 16'h0);
    check("age_switch_older_tag", iss_tag, 2);
    check("age_switch_r1data", iss_r1data, 16'h0D0D);
    iss_ready = 1'b1;
    tick();
    check("age_then_r_tag", iss_tag, 3);
    tick();
    check("age_count_0", count, 0);

    // T5: dispatch bypass of src2, then both sources woken by one broadcast.
    disp(16'h5000, 16'h0500, 4'd8, 1'b1, 16'h0011, 4'd0, 1'b0, 16'h0, 4'd5);
    cdb(1'b1, 4'd5, 16'h1234);
    tick();
    disp_valid = 1'b0;
    cdb(1'b0, 4'd0, 16'h0);
    check("t5_bypass_valid", iss_valid, 1);
    check("t5_bypass_r2data", iss_r2data, 16'h1234);
    check("t5_bypass_tag", iss_tag, 8);
    tick();
    disp(16'h5100, 16'h0510, 4'd9, 1'b0, 16'h0, 4'd14, 1'b0, 16'h0, 4'd14);
    tick();
    disp_valid = 1'b0;
    check("t5_both_wait", iss_valid, 0);
    cdb(1'b1, 4'd14, 16'h0E0E);
    tick();
    cdb(1'b0, 4'd0, 16'h0);
    check("t5_both_r1data", iss_r1data, 16'h0E0E);
    check("t5_both_r2data", iss_r2data, 16'h0E0E);
    tick();
    check("t5_count_0", count, 0);

    // T6b: T1 again with an asynchronous reset pulse between edges.
    disp(16'h1234, 16'h0100, 4'd1, 1'b1, 16'd5, 4'd0, 1'b1, 16'd7, 4'd0);
    tick();
    disp_valid = 1'b0;
    iss_ready = 1'b0;
    check("t6_pre_rst_valid", iss_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_iss_valid", iss_valid, 0);
    check("t6_async_r1data", iss_r1data, 0);
    check("t6_async_count", count, 0);
    check("t6_async_disp_ready", disp_ready, 1);
    rst = 1'b0;
    tick();
    check("t6_post_rst_idle", iss_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
